// File: rtl/seven_seg_capture.sv
// Seven-segment bus monitor: settles, decodes and frames a 4-digit display scan.
// Optional dp capture enabled by defining SEVEN_SEG_CAPTURE_DP_EN.
module seven_seg_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  digit_valid,
  output logic        bad_pattern,
  output logic        bad_sticky,
  output logic [3:0]  dp_out
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  localparam logic [7:0] SET_N = 8'(SETTLE_CYCLES);

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h27: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [6:0]        seg_q, seg_prev_q;
  logic [3:0]        an_q, an_prev_q;
  logic [3:0][3:0]   staging_q, staging_d;
  logic [15:0]       value_q, value_d;
  logic              fv_q, fv_d;
  logic [3:0]        dv_q, dv_d;
  logic              bad_q, bad_d;
  logic              sticky_q, sticky_d;
  logic              sel_ok;
  logic [1:0]        idx;
  logic              changed;
  logic              capture;
  logic [4:0]        dec;

  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    case (an_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

`ifdef SEVEN_SEG_CAPTURE_DP_EN
  logic       dp_q, dp_prev_q;
  logic [3:0] dpo_q, dpo_d;

  assign changed = (an_q != an_prev_q) || (seg_q != seg_prev_q) ||
                   (dp_q != dp_prev_q);
  assign dp_out  = dpo_q;

  always_comb begin
    dpo_d = dpo_q;
    if (capture) dpo_d[idx] = ~dp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_q      <= 1'b1;
      dp_prev_q <= 1'b1;
      dpo_q     <= 4'b0000;
    end else begin
      dp_q      <= dp;
      dp_prev_q <= dp_q;
      dpo_q     <= dpo_d;
    end
  end
`else
  assign changed = (an_q != an_prev_q) || (seg_q != seg_prev_q);
  // dp is deliberately ignored in this build
  assign dp_out  = 4'b0000 & {4{dp}};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (changed) begin
          cnt_d = 8'd1;
        end else if (cnt_q < SET_N) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!sel_ok) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (changed) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (state_d == SETTLE && cnt_d == SET_N) begin
      capture = 1'b1;
      state_d = HELD;
    end
  end

  assign dec = decode(seg_q);

  always_comb begin
    staging_d = staging_q;
    value_d   = value_q;
    dv_d      = dv_q;
    bad_d     = 1'b0;
    fv_d      = (dv_q == 4'b1111);
    if (fv_d) begin
      value_d = staging_q;
      dv_d    = 4'b0000;
    end
    // a capture on the frame cycle lands after the clear
    if (capture) begin
      if (dec[4]) begin
        staging_d[idx] = dec[3:0];
        dv_d[idx]      = 1'b1;
      end else begin
        bad_d     = 1'b1;
        dv_d[idx] = 1'b0;
      end
    end
    sticky_d = sticky_q | bad_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      seg_q      <= 7'h7F;
      seg_prev_q <= 7'h7F;
      an_q       <= 4'hF;
      an_prev_q  <= 4'hF;
      staging_q  <= '0;
      value_q    <= 16'h0000;
      fv_q       <= 1'b0;
      dv_q       <= 4'b0000;
      bad_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg;
      seg_prev_q <= seg_q;
      an_q       <= an;
      an_prev_q  <= an_q;
      staging_q  <= staging_d;
      value_q    <= value_d;
      fv_q       <= fv_d;
      dv_q       <= dv_d;
      bad_q      <= bad_d;
      sticky_q   <= sticky_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = fv_q;
  assign digit_valid = dv_q;
  assign bad_pattern = bad_q;
  assign bad_sticky  = sticky_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with a frame scoreboard.
// Second instance runs with SETTLE_CYCLES=1 for the minimum-latency case.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic        dp  = 1'b1;

  logic [15:0] value, value1;
  logic        frame_valid, frame_valid1;
  logic [3:0]  digit_valid, digit_valid1;
  logic        bad_pattern, bad_pattern1;
  logic        bad_sticky, bad_sticky1;
  logic [3:0]  dp_out, dp_out1;

  int tests = 0;
  int fails = 0;
  int bad_cnt = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  seven_seg_capture #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .dp(dp),
    .value(value), .frame_valid(frame_valid),
    .digit_valid(digit_valid), .bad_pattern(bad_pattern),
    .bad_sticky(bad_sticky), .dp_out(dp_out)
  );

  seven_seg_capture #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .dp(dp),
    .value(value1), .frame_valid(frame_valid1),
    .digit_valid(digit_valid1), .bad_pattern(bad_pattern1),
    .bad_sticky(bad_sticky1), .dp_out(dp_out1)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; sample #1 after the edge and service the scoreboard
  task automatic cyc();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (bad_pattern === 1'b1) bad_cnt++;
    if (frame_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("frame_unexpected", value, 16'hxxxx);
      end else begin
        e = sb_q.pop_front();
        chk("frame_value", value, e);
      end
    end
  endtask

  task automatic scan(input logic [3:0] a, input logic [6:0] s,
                      input int n);
    an  = a;
    seg = s;
    repeat (n) cyc();
  endtask

  initial begin
    // reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      seg = 7'($urandom);
      an  = 4'($urandom);
      dp  = 1'($urandom);
      cyc();
    end
    chk("rst_value", value, 16'h0000);
    chk("rst_fv", {15'd0, frame_valid}, 16'd0);
    chk("rst_dv", {12'd0, digit_valid}, 16'd0);
    chk("rst_bad", {15'd0, bad_pattern}, 16'd0);
    chk("rst_sticky", {15'd0, bad_sticky}, 16'd0);
    chk("rst_dp_out", {12'd0, dp_out}, 16'd0);
    rst = 1'b0;
    dp  = 1'b1;
    scan(4'hF, 7'h40, 10);
    chk("blank_dv", {12'd0, digit_valid}, 16'd0);
    chk("blank_bad", bad_cnt[15:0], 16'd0);

    // single digit latency: 1 + SETTLE_CYCLES
    an  = 4'b1110;
    seg = 7'h40;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("single_dv_lat", {12'd0, digit_valid}, (i == 5) ? 16'd1 : 16'd0);
      if (i <= 2)
        chk("s1_dv_lat", {12'd0, digit_valid1}, (i == 2) ? 16'd1 : 16'd0);
    end
    scan(4'hF, 7'h7F, 3);
    chk("single_dv_hold", {12'd0, digit_valid}, 16'd1);

    // full frame 4123
    sb_q.push_back(16'h4123);
    scan(4'b1110, 7'h30, 6);
    scan(4'b1101, 7'h24, 6);
    scan(4'b1011, 7'h79, 6);
    scan(4'b0111, 7'h19, 6);
    scan(4'hF, 7'h7F, 3);
    chk("frame1_drain", 16'(sb_q.size()), 16'd0);
    chk("frame1_dv_clr", {12'd0, digit_valid}, 16'd0);
    chk("frame1_value", value, 16'h4123);

    // glitch: short 0 then settled 1 on digit 0
    scan(4'b1110, 7'h40, 3);
    scan(4'b1110, 7'h79, 4);
    scan(4'hF, 7'h7F, 3);
    chk("glitch_dv", {12'd0, digit_valid}, 16'd1);
    sb_q.push_back(16'h4321);
    scan(4'b1101, 7'h24, 6);
    scan(4'b1011, 7'h30, 6);
    scan(4'b0111, 7'h19, 6);
    scan(4'hF, 7'h7F, 3);
    chk("glitch_drain", 16'(sb_q.size()), 16'd0);

    // bad pattern then multi-hot select
    scan(4'b1110, 7'h7F, 5);
    scan(4'hF, 7'h7F, 3);
    chk("bad_pulses", bad_cnt[15:0], 16'd1);
    chk("bad_sticky", {15'd0, bad_sticky}, 16'd1);
    chk("bad_dv", {12'd0, digit_valid}, 16'd0);
    scan(4'b1100, 7'h40, 8);
    scan(4'hF, 7'h7F, 2);
    chk("multi_dv", {12'd0, digit_valid}, 16'd0);
    chk("multi_bad", bad_cnt[15:0], 16'd1);
    chk("dp_out_off", {12'd0, dp_out}, 16'd0);

    // reset mid-frame discards partial digits
    scan(4'b1110, 7'h12, 6);
    scan(4'b1101, 7'h02, 6);
    scan(4'b1011, 7'h78, 6);
    chk("mid_dv", {12'd0, digit_valid}, 16'h7);
    rst = 1'b1;
    scan(4'hF, 7'h7F, 2);
    rst = 1'b0;
    chk("mid_rst_dv", {12'd0, digit_valid}, 16'd0);
    chk("mid_rst_value", value, 16'h0000);
    chk("mid_rst_sticky", {15'd0, bad_sticky}, 16'd0);
    scan(4'hF, 7'h7F, 2);
    sb_q.push_back(16'hBA98);
    scan(4'b1110, 7'h00, 6);
    scan(4'b1101, 7'h10, 6);
    scan(4'b1011, 7'h08, 6);
    chk("post_rst_no_frame", value, 16'h0000);
    scan(4'b0111, 7'h03, 6);
    scan(4'hF, 7'h7F, 4);
    chk("post_rst_drain", 16'(sb_q.size()), 16'd0);
    chk("post_rst_value", value, 16'hBA98);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
